pool_window_buffer: RTL and testbench
=====================================

Name: pool_window_buffer

Overview:
Upstream neighbour of max_pooling. Accepts the convolution result stream, one 36-bit value per beat in raster order, MAP_W columns by MAP_H rows. Buffers one row and assembles non-overlapping 2x2 windows. Presents each window as four registered 36-bit values, with a valid/ready handshake, ready to wire straight into max_pooling's conv_val0..3.

Parameters:
DATA_W, 36, width of one conv value; must equal max_pooling operand width
MAP_W, 4, conv map columns; even, >=2
MAP_H, 4, conv map rows; even, >=2

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  conv value present
in_ready  out  1  block can accept a value this cycle
in_data  in  DATA_W  conv value, raster order, row 0 col 0 first
out_valid  out  1  window registers hold an unconsumed window
out_ready  in  1  downstream consumes window
win0  out  DATA_W  top-left (row 2r, col 2c)
win1  out  DATA_W  top-right (row 2r, col 2c+1)
win2  out  DATA_W  bottom-left (row 2r+1, col 2c)
win3  out  DATA_W  bottom-right (row 2r+1, col 2c+1)
frame_done  out  1  one-cycle pulse when last window of a frame is consumed

Behaviour:
- Reset (rst=1 at clk edge): col=0, row=0, out_valid=0, win0..3=0, frame_done=0, held value=0. Row-buffer contents are don't-care. Reset mid-frame discards the partial frame and any pending window. The next accepted beat is row 0 col 0.
- Beat accepted iff in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational and independent of in_valid. Upstream may hold in_valid with stable in_data while in_ready=0.
- col counter 0..MAP_W-1 and row counter 0..MAP_H-1 advance on each accepted beat. col wraps to 0 and row increments at col=MAP_W-1. Both wrap to 0 after (MAP_W-1, MAP_H-1), and the next beat starts a new frame with no idle cycle required.
- Even row: in_data is written to row_buf[col] (MAP_W x DATA_W). No output.
- Odd row, even col: in_data is held in a single bottom-left register.
- Odd row, odd col: at the same edge, win0=row_buf[col-1], win1=row_buf[col], win2=held value, win3=in_data, and out_valid is set to 1. Latency is 1 cycle from the accepting edge to out_valid.
- out_valid clears on out_ready && out_valid, unless a new window loads at the same edge; in that case it stays 1 with the new data. This gives full throughput of one window per two odd-row beats, with no bubble.
- win0..3 are stable while out_valid && !out_ready.
- out_ready while out_valid=0 has no effect.
- frame_done is high for exactly one cycle, on the cycle after consumption of the window formed at (MAP_H-1, MAP_W-1). It is 0 otherwise and 0 during reset.
- Data is treated as opaque bits; no arithmetic, no sign handling.

Optional Feature:
Macro POOL_WINDOW_MAX_EN.
- Defined: adds output port max_val [DATA_W-1:0], driven by an internal max_pooling instance fed from win0..3. It is valid whenever out_valid=1 and has the same comparison semantics as max_pooling.
- Undefined: no max_val port and no comparator logic; the module is a pure window former.

Decomposition:
- Shared package pool_pkg holds CONV_DATA_W=36 and the window index constants WIN_TL=0, WIN_TR=1, WIN_BL=2, WIN_BR=3.
- One natural sub-module: pool_row_buffer, a MAP_W-deep DATA_W register array with write at col and two read ports (col-1, col).
- max_pooling is reused as-is under the macro.

Test Plan:
- 4x4 map, values 1..16 raster, out_ready=1 -> windows (1,2,5,6), (3,4,7,8), (9,10,13,14), (11,12,15,16) in order; frame_done pulses once after the 4th.
- Same map, out_ready=0 held after the first window -> win0..3 stay (1,2,5,6) and in_ready=0 on the first stalled cycle; release -> remaining windows arrive with nothing lost or duplicated.
- Back-to-back frames: values 1..16 then 101..116, no gap -> 8 windows; the 5th is (101,102,105,106); frame_done pulses twice.
- rst=1 asserted after the 10th beat, then values 1..16 -> output matches scenario 1 exactly; out_valid=0 in the cycle after reset.
- Random in_valid/out_ready toggling, MAP_W=6, MAP_H=4, 24 random 36-bit values -> windows match a reference model bit-for-bit, including values 36'hFFFFFFFFF and 36'h800000000.
- POOL_WINDOW_MAX_EN defined, window (36'h123456789, 36'h987654321, 36'h111111111, 36'h0FFFFFFFF) -> max_val equals max_pooling's output for the same four operands.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared constants for the pooling front end: conv operand width and the
// position of each value inside a 2x2 window.
package pool_pkg;

  localparam int CONV_DATA_W = 36;

  localparam int WIN_TL = 0;
  localparam int WIN_TR = 1;
  localparam int WIN_BL = 2;
  localparam int WIN_BR = 3;
  localparam int WIN_N  = 4;

endpackage

// File: rtl/pool_row_buffer.sv
// One conv row of storage: written at the current column during even rows,
// read at columns col-1 and col while the following odd row closes windows.
module pool_row_buffer #(
  parameter int DATA_W = 36,
  parameter int MAP_W  = 4,
  parameter int COL_W  = 2
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [COL_W-1:0]  i_col,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_prev,
  output logic [DATA_W-1:0] o_rd_cur
);

  logic [DATA_W-1:0] r_mem [MAP_W];
  logic [COL_W-1:0]  w_col_prev;

  // NOTE: storage is deliberately left out of reset; every entry is rewritten
  // by the even row before the odd row reads it, so reset would only cost area.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_col] <= i_wr_data;
  end

  assign w_col_prev = i_col - COL_W'(1);
  assign o_rd_prev  = r_mem[w_col_prev];
  assign o_rd_cur   = r_mem[i_col];

endmodule

// File: rtl/pool_window_buffer.sv
// Raster conv stream in, registered non-overlapping 2x2 windows out with a
// valid/ready handshake. Macro POOL_WINDOW_MAX_EN adds a max_val output.
module pool_window_buffer
  import pool_pkg::*;
#(
  parameter int DATA_W = CONV_DATA_W,
  parameter int MAP_W  = 4,
  parameter int MAP_H  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] win0,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic [DATA_W-1:0] win3,
  output logic              frame_done
`ifdef POOL_WINDOW_MAX_EN
  ,
  output logic [DATA_W-1:0] max_val
`endif
);

  localparam int COL_W = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int ROW_W = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAP_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAP_H - 1);

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [DATA_W-1:0] r_held;
  logic [DATA_W-1:0] r_win [WIN_N];
  logic              r_out_valid;
  logic              r_win_last;
  logic              r_frame_done;

  logic              w_accept;
  logic              w_consume;
  logic              w_load;
  logic              w_col_last;
  logic              w_row_last;
  logic [DATA_W-1:0] w_buf_prev;
  logic [DATA_W-1:0] w_buf_cur;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_consume  = r_out_valid && out_ready;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_load     = w_accept && r_row[0] && r_col[0];

  pool_row_buffer #(
    .DATA_W (DATA_W),
    .MAP_W  (MAP_W),
    .COL_W  (COL_W)
  ) u_row_buf (
    .clk       (clk),
    .i_wr_en   (w_accept && !r_row[0]),
    .i_col     (r_col),
    .i_wr_data (in_data),
    .o_rd_prev (w_buf_prev),
    .o_rd_cur  (w_buf_cur)
  );

  // NOTE: non-blocking assignments in every clocked block, so all registers
  // update together from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // A new window overrides the consume-clear so back-to-back windows never bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_held       <= '0;
      r_out_valid  <= 1'b0;
      r_win_last   <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < WIN_N; i++) r_win[i] <= '0;
    end else begin
      r_frame_done <= w_consume && r_win_last;
      if (w_accept && r_row[0] && !r_col[0]) r_held <= in_data;
      if (w_load) begin
        r_win[WIN_TL] <= w_buf_prev;
        r_win[WIN_TR] <= w_buf_cur;
        r_win[WIN_BL] <= r_held;
        r_win[WIN_BR] <= in_data;
        r_out_valid   <= 1'b1;
        r_win_last    <= w_row_last && w_col_last;
      end else if (w_consume) begin
        r_out_valid   <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign win0       = r_win[WIN_TL];
  assign win1       = r_win[WIN_TR];
  assign win2       = r_win[WIN_BL];
  assign win3       = r_win[WIN_BR];
  assign frame_done = r_frame_done;

`ifdef POOL_WINDOW_MAX_EN
  max_pooling u_max (
    .conv_val0 (r_win[WIN_TL]),
    .conv_val1 (r_win[WIN_TR]),
    .conv_val2 (r_win[WIN_BL]),
    .conv_val3 (r_win[WIN_BR]),
    .max_val   (max_val)
  );
`endif

endmodule

// File: tb/tb_pool_window_buffer.sv
// Bench for pool_window_buffer: a 4x4 and a 6x4 instance share stimulus, `sel`
// picks the one observed; windows are checked against a raster-level model.
module tb_pool_window_buffer;
  import pool_pkg::*;

  localparam int DW = CONV_DATA_W;
  typedef logic [WIN_N-1:0][DW-1:0] win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          sel = 1'b0;

  logic a_in_ready, a_out_valid, a_frame_done;
  logic b_in_ready, b_out_valid, b_frame_done;
  logic [DW-1:0] a_w0, a_w1, a_w2, a_w3, b_w0, b_w1, b_w2, b_w3;

  logic obs_in_ready, obs_out_valid, obs_frame_done;
  win_t obs_win;

`ifdef POOL_WINDOW_MAX_EN
  logic [DW-1:0] a_max, b_max, ref_max;
  logic [DW-1:0] k0 = 36'h123456789, k1 = 36'h987654321;
  logic [DW-1:0] k2 = 36'h111111111, k3 = 36'h0FFFFFFFF;
  max_pooling u_ref (.conv_val0(k0), .conv_val1(k1), .conv_val2(k2), .conv_val3(k3), .max_val(ref_max));
`endif

  pool_window_buffer #(.DATA_W(DW), .MAP_W(4), .MAP_H(4)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .win0(a_w0), .win1(a_w1), .win2(a_w2), .win3(a_w3), .frame_done(a_frame_done)
`ifdef POOL_WINDOW_MAX_EN
    , .max_val(a_max)
`endif
  );

  pool_window_buffer #(.DATA_W(DW), .MAP_W(6), .MAP_H(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .win0(b_w0), .win1(b_w1), .win2(b_w2), .win3(b_w3), .frame_done(b_frame_done)
`ifdef POOL_WINDOW_MAX_EN
    , .max_val(b_max)
`endif
  );

  assign obs_in_ready   = sel ? b_in_ready   : a_in_ready;
  assign obs_out_valid  = sel ? b_out_valid  : a_out_valid;
  assign obs_frame_done = sel ? b_frame_done : a_frame_done;
  assign obs_win[WIN_TL] = sel ? b_w0 : a_w0;
  assign obs_win[WIN_TR] = sel ? b_w1 : a_w1;
  assign obs_win[WIN_BL] = sel ? b_w2 : a_w2;
  assign obs_win[WIN_BR] = sel ? b_w3 : a_w3;

  int checks = 0;
  int failures = 0;
  int cur_w = 4;
  int cur_h = 4;
  bit stop = 1'b0;

  logic [DW-1:0] stim[$];
  win_t got[$];
  win_t exp_q[$];
  int   fd_pos[$];
  int   exp_fd[$];

  // Consumption happens at the next rising edge when valid && ready hold here.
  always @(negedge clk) begin
    if (obs_frame_done) fd_pos.push_back(got.size());
    if (obs_out_valid && out_ready) got.push_back(obs_win);
  end

  function automatic logic [DW-1:0] rand36();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  function automatic win_t mk_win(input logic [DW-1:0] tl, tr, bl, br);
    win_t w;
    w[WIN_TL] = tl; w[WIN_TR] = tr; w[WIN_BL] = bl; w[WIN_BR] = br;
    return w;
  endfunction

  // Reference: cut the raster stream into frames and pick each 2x2 block.
  function automatic void build_expected();
    int per, nframes, t;
    exp_q.delete();
    exp_fd.delete();
    per = cur_w * cur_h;
    nframes = stim.size() / per;
    for (int f = 0; f < nframes; f++) begin
      for (int r = 0; r < cur_h / 2; r++) begin
        for (int c = 0; c < cur_w / 2; c++) begin
          t = f * per + 2 * r * cur_w + 2 * c;
          exp_q.push_back(mk_win(stim[t], stim[t + 1], stim[t + cur_w], stim[t + cur_w + 1]));
        end
      end
      exp_fd.push_back(exp_q.size());
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic feed(input bit gaps, input int count);
    int waited;
    for (int i = 0; i < count; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data = rand36();
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data = stim[i];
      waited = 0;
      @(negedge clk);
      while (!obs_in_ready && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (!obs_in_ready) begin
        checks++; failures++;
        $display("FAIL feed_timeout beat=%0d in_ready=%b required=1 within 200 cycles", i, obs_in_ready);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic ready_ctl(input int mode);
    int waited;
    if (mode == 0) begin
      out_ready = 1'b1;
      while (!stop) @(posedge clk);
    end else if (mode == 1) begin
      out_ready = 1'b0;
      waited = 0;
      @(negedge clk);
      while (!obs_out_valid && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      if (obs_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_in_ready actual=%b required=0", obs_in_ready);
      end
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (obs_out_valid !== 1'b1 || obs_win !== exp_q[0]) begin
          failures++;
          $display("FAIL stall_hold cycle=%0d valid=%b win=%h required valid=1 win=%h",
                   k, obs_out_valid, obs_win, exp_q[0]);
        end
        @(negedge clk);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      while (!stop) @(posedge clk);
    end else begin
      while (!stop) begin
        @(posedge clk);
        #1 out_ready = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b1;
    end
  endtask

  task automatic run(input string name, input int mode, input bit gaps);
    int n;
    bit fd_ok;
    build_expected();
    got.delete();
    fd_pos.delete();
    stop = 1'b0;
    fork
      begin
        feed(gaps, stim.size());
        n = 0;
        while (got.size() < exp_q.size() && n < 500) begin
          @(posedge clk);
          n++;
        end
        repeat (3) @(posedge clk);
        stop = 1'b1;
      end
      ready_ctl(mode);
    join
    #1 out_ready = 1'b1;
    checks++;
    if (got.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_count windows=%0d required=%0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_win%0d actual=%h required=%h", name, i, got[i], exp_q[i]);
      end
    end
    fd_ok = (fd_pos.size() == exp_fd.size());
    for (int i = 0; fd_ok && i < fd_pos.size(); i++) fd_ok = (fd_pos[i] == exp_fd[i]);
    checks++;
    if (!fd_ok) begin
      failures++;
      $display("FAIL %s_frame_done pulses=%0d (first after %0d windows) required=%0d pulses",
               name, fd_pos.size(), (fd_pos.size() > 0) ? fd_pos[0] : -1, exp_fd.size());
    end
  endtask

  function automatic void load_ramp(input int base, input int n, input bit clear);
    if (clear) stim.delete();
    for (int i = 1; i <= n; i++) stim.push_back(DW'(base + i));
  endfunction

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    @(negedge clk);
    checks++;
    if (obs_out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid actual=%b required=0", obs_out_valid);
    end
    checks++;
    if (obs_in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready actual=%b required=1", obs_in_ready);
    end
    checks++;
    if (obs_frame_done !== 1'b0) begin
      failures++; $display("FAIL reset_frame_done actual=%b required=0", obs_frame_done);
    end
    checks++;
    if (obs_win !== '0) begin
      failures++; $display("FAIL reset_win actual=%h required=0", obs_win);
    end
  endtask

  task automatic test_raster();
    sel = 1'b0; cur_w = 4; cur_h = 4;
    do_reset();
    load_ramp(0, 16, 1'b1);
    run("raster", 0, 1'b0);
  endtask

  task automatic test_stall();
    sel = 1'b0; cur_w = 4; cur_h = 4;
    do_reset();
    load_ramp(0, 16, 1'b1);
    run("stall", 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; cur_w = 4; cur_h = 4;
    do_reset();
    load_ramp(0, 16, 1'b1);
    load_ramp(100, 16, 1'b0);
    run("b2b", 0, 1'b0);
    checks++;
    if (got.size() < 5 || got[4] !== mk_win(36'd101, 36'd102, 36'd105, 36'd106)) begin
      failures++;
      $display("FAIL b2b_fifth actual=%h required=(101,102,105,106)", (got.size() >= 5) ? got[4] : '0);
    end
  endtask

  task automatic test_reset_midframe();
    sel = 1'b0; cur_w = 4; cur_h = 4;
    do_reset();
    load_ramp(0, 16, 1'b1);
    out_ready = 1'b1;
    feed(1'b0, 10);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_out_valid !== 1'b0) begin
      failures++; $display("FAIL midreset_out_valid actual=%b required=0", obs_out_valid);
    end
    @(posedge clk);
    #1;
    run("midreset", 0, 1'b0);
  endtask

  task automatic test_random();
    sel = 1'b1; cur_w = 6; cur_h = 4;
    do_reset();
    for (int it = 0; it < 3; it++) begin
      stim.delete();
      for (int i = 0; i < 24; i++) stim.push_back(rand36());
      stim[3 + it] = 36'hFFFFFFFFF;
      stim[9 + it] = 36'h800000000;
      run("random", 2, 1'b1);
    end
  endtask

`ifdef POOL_WINDOW_MAX_EN
  task automatic test_max();
    int waited;
    sel = 1'b0; cur_w = 4; cur_h = 4;
    do_reset();
    load_ramp(0, 16, 1'b1);
    stim[0] = k0; stim[1] = k1; stim[4] = k2; stim[5] = k3;
    out_ready = 1'b0;
    feed(1'b0, 6);
    waited = 0;
    @(negedge clk);
    while (!obs_out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (obs_out_valid !== 1'b1 || a_max !== ref_max) begin
      failures++;
      $display("FAIL max_val valid=%b actual=%h required=%h", obs_out_valid, a_max, ref_max);
    end
    do_reset();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_raster();
    test_stall();
    test_back_to_back();
    test_reset_midframe();
    test_random();
`ifdef POOL_WINDOW_MAX_EN
    test_max();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
